// File: rtl/mul8_acc.sv
// ---------------------------------------------------------------------------
// mul8_acc
//
// Accumulation stage for the 8x8 multiplier family. It adds up a frame of
// 16-bit unsigned products in a saturating ACC_W-bit accumulator. It then
// holds the frame total on an output handshake until a consumer takes it.
//
// Frame length is sampled from `len` on the first beat of each frame. A
// length of 0 behaves as 1. Changes to `len` after the first beat are
// ignored.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   len      in   products per frame (0 treated as 1)
//   p_valid  in   product beat valid
//   p_ready  out  stage can accept a product; depends on state only
//   p        in   16-bit unsigned product
//   s_valid  out  frame result valid
//   s_ready  in   consumer accepts the result
//   s        out  saturated frame sum
//   s_ovf    out  saturation occurred somewhere in this frame
//   s_cnt    out  number of beats summed
// ---------------------------------------------------------------------------
module mul8_acc #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] len,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [15:0]      p,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [ACC_W-1:0] s,
    output logic             s_ovf,
    output logic [CNT_W-1:0] s_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] len_q, len_q_nxt;
    logic             ovf, ovf_nxt;
    logic             rdy_q;

    logic             accept;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W:0]   sum;

    // rdy_q keeps p_ready low through reset. It rises on the first clock
    // edge after reset is released.
    assign p_ready = rdy_q && (state != HOLD);
    assign s_valid = (state == HOLD);
    assign s       = acc;
    assign s_ovf   = ovf;
    assign s_cnt   = cnt;

    assign accept  = p_valid && p_ready;
    assign len_eff = (len == '0) ? CNT_W'(1) : len;
    assign cnt_inc = cnt + CNT_W'(1);
    // One extra bit so the carry out of the accumulator is visible.
    assign sum     = {1'b0, acc} + (ACC_W+1)'(p);

    always_comb begin
        // NOTE: every signal driven here gets a default first. An incomplete
        // assignment path would otherwise infer a latch.
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        len_q_nxt = len_q;
        ovf_nxt   = ovf;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = ACC_W'(p);
                    cnt_nxt   = CNT_W'(1);
                    len_q_nxt = len_eff;
                    ovf_nxt   = 1'b0;
                    state_nxt = (len_eff == CNT_W'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // Once saturated, acc is all-ones. Any later nonzero
                    // beat carries out again, so acc stays pinned.
                    if (sum[ACC_W]) begin
                        acc_nxt = '1;
                        ovf_nxt = 1'b1;
                    end else begin
                        acc_nxt = sum[ACC_W-1:0];
                    end
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (s_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // every flop sampling pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            len_q <= len_q_nxt;
            ovf   <= ovf_nxt;
            rdy_q <= 1'b1;
        end
    end

endmodule

// File: doc/mul8_acc.md
# mul8_acc

Downstream accumulation stage for the 8x8 approximate multipliers.
- Consumes a stream of 16-bit products over a valid/ready handshake.
- Sums a programmable-length frame of products into a saturating ACC_W-bit accumulator.
- Presents the frame total, overflow flag and beat count on a second valid/ready interface.
- Sits between any `mul8_*` product output (registered by the feeder) and the dot-product / error-evaluation logic.

## Interface
Parameters:
- ACC_W, 24, accumulator/result width; must be ≥ 16.
- CNT_W, 8, width of frame-length and beat counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- LEN  in  CNT_W  products per frame; sampled on the first beat of a frame; 0 is treated as 1.
- P_VALID  in  1  product beat valid.
- P_READY  out  1  stage accepts a product this cycle.
- P  in  16  unsigned product.
- S_VALID  out  1  frame result valid.
- S_READY  in  1  consumer accepts the result.
- S  out  ACC_W  frame sum, saturated.
- S_OVF  out  1  sticky: saturation occurred in this frame.
- S_CNT  out  CNT_W  number of beats summed (= effective LEN).

## Operation
- A beat is accepted when P_VALID && P_READY. A result is taken when S_VALID && S_READY.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - P_READY = 1.
  - On accept: acc <= zero-extended P; cnt <= 1; len_q <= max(LEN, 1); ovf <= 0.
  - Next state: HOLD if len_q == 1, otherwise ACCUM.
- ACCUM:
  - P_READY = 1.
  - On accept: acc <= sat(acc + P); cnt <= cnt + 1; ovf <= ovf | carry.
  - Goes to HOLD when the accepted beat makes cnt == len_q.
  - Cycles without P_VALID leave all state unchanged.
- HOLD:
  - P_READY = 0; S_VALID = 1.
  - S = acc, S_OVF = ovf, S_CNT = cnt, all registered and held stable while S_READY = 0.
  - On S_READY: next state IDLE.
- Arithmetic:
  - The sum is computed at ACC_W+1 bits. If bit ACC_W is set, acc <= all-ones and ovf <= 1.
  - Once saturated, acc stays all-ones for the rest of the frame.
- LEN changes mid-frame are ignored; only len_q is used.
- P is not checked for range; any 16-bit value is summed as-is.

## Timing
- Reset (RST_N low, async):
  - State IDLE.
  - S_VALID = 0, S = 0, S_OVF = 0, S_CNT = 0.
  - acc, cnt, len_q = 0.
  - P_READY is forced 0 while RST_N is low and returns to 1 on the first rising edge after release.
- Latency: S_VALID rises on the first rising edge after the final beat is accepted, i.e. 1 cycle.
- Throughput:
  - One beat per cycle inside a frame.
  - Minimum frame period is len_q + 1 cycles, because HOLD lasts at least 1 cycle and accepts no beat.
- The next frame's first beat can be accepted on the cycle after the S handshake, when the FSM is in IDLE.
- Reset asserted mid-frame or in HOLD: the partial sum is discarded and no S_VALID is emitted. After release the next accepted beat starts a new frame.
- S_VALID, once high, never drops without an S handshake, except on reset.
- P_READY is a function of state only; it does not depend on P_VALID or S_READY.

## Test plan
- Reset mid-frame:
  - Stimulus: LEN=4, accept 2 beats, pulse RST_N low, then send LEN=2 with P=5, 7.
  - Required: no result for the aborted frame; S=12, S_CNT=2.
- Basic frame:
  - Stimulus: LEN=3, P=100, 200, 300 on consecutive cycles, S_READY=1.
  - Required: S_VALID 1 cycle after the 3rd beat; S=600, S_CNT=3, S_OVF=0; P_READY=0 for exactly 1 cycle.
- Bubbles and backpressure:
  - Stimulus: LEN=2, P=65535, gap of 3 idle cycles, P=1; S_READY held low for 5 cycles.
  - Required: S=65536 stable for all 6 HOLD cycles; no beat accepted during HOLD.
- Saturation (ACC_W=17):
  - Stimulus: LEN=4, four beats of P=65535.
  - Required: S=131071, S_OVF=1, S_CNT=4.
  - Then a new frame with LEN=1, P=9 gives S=9, S_OVF=0.
- LEN=0 and mid-frame LEN change:
  - Stimulus: LEN=0 with P=42.
  - Required: result after 1 beat, S=42, S_CNT=1.
  - Stimulus: LEN=2, then LEN changed to 5 after the first beat.
  - Required: frame still closes after 2 beats.
